ref_arb: RTL
============

// Module: ref_arb
// PURPOSE
//  Consumes the refresh request flags of the SDRAM refresh counter (auto_ref, p_auto_ref).
//  Waits for the in-flight user transfer to finish, then issues PRECHARGE-ALL followed by
//  AUTO REFRESH, honouring tRP and tRFC, and pulses clr_ref to re-arm the counter.
//  Sits between the refresh counter and the SDRAM command output mux of the controller.
// PARAMETERS
//  T_RP      3   cycles from PRECHARGE command to AUTO REFRESH command (>=1)
//  T_RFC     7   cycles from AUTO REFRESH command to DONE state (>=1)
//  LATE_MAX  64  cycles auto_ref may wait in IDLE before ref_late is set
//  CNT_W     8   width of internal wait counters; must hold max(T_RP,T_RFC,LATE_MAX)
// PORTS
//  Clk         in   1  system clock, all logic on rising edge
//  Reset       in   1  asynchronous, active-low reset
//  auto_ref    in   1  refresh due; held high until clr_ref is seen
//  p_auto_ref  in   1  refresh pre-warning (refresh due in ~3 cycles)
//  xfer_busy   in   1  user read/write burst in progress; refresh must not start
//  hold_off    out  1  tells main FSM not to start a new transfer
//  ref_busy    out  1  refresh sequence in progress (state != IDLE)
//  clr_ref     out  1  one-cycle pulse; clears auto_ref/p_auto_ref in the counter
//  sd_cs_n     out  1  SDRAM chip select, registered
//  sd_ras_n    out  1  SDRAM RAS, registered
//  sd_cas_n    out  1  SDRAM CAS, registered
//  sd_we_n     out  1  SDRAM WE, registered
//  sd_a10      out  1  SDRAM A10 (precharge-all select), registered
//  ref_late    out  1  sticky: refresh start waited more than LATE_MAX cycles
// BEHAVIOUR
//  Reset (async, Reset=0): state=IDLE, counters=0, clr_ref=0, ref_late=0, cmd=NOP
//   (cs_n=0, ras_n=1, cas_n=1, we_n=1, a10=0). Mid-sequence reset aborts immediately; no resume.
//  FSM: IDLE -> PRE -> WAIT_RP -> AREF -> WAIT_RFC -> DONE -> IDLE.
//   IDLE: go to PRE when auto_ref=1 and xfer_busy=0; otherwise stay.
//   PRE (1 cycle): cmd PRECHARGE (ras_n=0, cas_n=1, we_n=0, a10=1).
//   WAIT_RP: NOPs for T_RP-1 cycles; skipped when T_RP=1.
//   AREF (1 cycle): cmd AUTO REFRESH (ras_n=0, cas_n=0, we_n=1, a10=0).
//   WAIT_RFC: NOPs for T_RFC-1 cycles; skipped when T_RFC=1.
//   DONE (1 cycle): clr_ref=1 and cmd NOP; unconditional return to IDLE.
//  Command/clr_ref outputs are registered and valid in the cycle the FSM is in that state.
//   PRE-to-AREF spacing is exactly T_RP cycles. PRE-to-DONE inclusive is T_RP+T_RFC+1 cycles.
//  auto_ref falls the cycle after DONE, so IDLE never re-triggers on a stale flag.
//   A new auto_ref raised in the same cycle is lost in the counter by design (clr_ref wins).
//  hold_off = p_auto_ref | auto_ref | ref_busy (combinational); xfer_busy is never forced low.
//  xfer_busy is ignored outside IDLE.
//  Late counter: increments each IDLE cycle with auto_ref=1 and xfer_busy=1; cleared on PRE.
//   It saturates at LATE_MAX, and ref_late is set the cycle the count reaches LATE_MAX.
//   ref_late clears only on reset.
//  Simultaneous auto_ref and xfer_busy falling edge: refresh starts the first cycle xfer_busy=0.
// TESTING
//  1 Reset, xfer_busy=0, pulse auto_ref high -> PRE next cycle, AREF 3 cycles later,
//    DONE 7 cycles after AREF (11 cycles PRE..DONE), clr_ref exactly 1 cycle.
//  2 auto_ref=1 with xfer_busy=1 for 20 cycles -> hold_off=1 throughout, no PRE.
//    PRE in first cycle after xfer_busy=0; ref_late stays 0.
//  3 xfer_busy held 70 cycles with auto_ref=1 -> ref_late=1 after cycle 64.
//    It remains 1 after the refresh completes.
//  4 Reset=0 asserted during WAIT_RFC -> outputs return to NOP and ref_busy=0 asynchronously.
//    No clr_ref pulse occurs.
//  5 T_RP=1, T_RFC=1 build -> PRE, AREF, DONE in 3 consecutive cycles.
//  6 Back-to-back: auto_ref reasserts 2 cycles after DONE -> second sequence starts cleanly.
//    Command encodings match case 1.

Source files
------------

// File: rtl/ref_arb.sv
// Refresh arbiter: waits for the in-flight transfer, then issues PRECHARGE-ALL and
// AUTO REFRESH with tRP/tRFC spacing, and acknowledges the refresh counter with clr_ref.
module ref_arb #(
    parameter int T_RP     = 3,
    parameter int T_RFC    = 7,
    parameter int LATE_MAX = 64,
    parameter int CNT_W    = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       auto_ref,
    input  logic       p_auto_ref,
    input  logic       xfer_busy,
    output logic       hold_off,
    output logic       ref_busy,
    output logic       clr_ref,
    output logic       sd_cs_n,
    output logic       sd_ras_n,
    output logic       sd_cas_n,
    output logic       sd_we_n,
    output logic       sd_a10,
    output logic       ref_late,
    output logic [2:0] dbg_state
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PRE      = 3'd1;
    localparam logic [2:0] S_WAIT_RP  = 3'd2;
    localparam logic [2:0] S_AREF     = 3'd3;
    localparam logic [2:0] S_WAIT_RFC = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    localparam logic [CNT_W-1:0] RP_LOAD  = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] RFC_LOAD = CNT_W'(T_RFC - 1);
    localparam logic [CNT_W-1:0] LATE_LIM = CNT_W'(LATE_MAX);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    // Command bus order: {cs_n, ras_n, cas_n, we_n, a10}
    localparam logic [4:0] CMD_NOP  = 5'b01110;
    localparam logic [4:0] CMD_PRE  = 5'b00101;
    localparam logic [4:0] CMD_AREF = 5'b00010;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_nxt;
    logic [CNT_W-1:0] late_cnt;
    logic [CNT_W-1:0] late_nxt;
    logic [4:0]       cmd_q;
    logic [4:0]       cmd_nxt;
    logic             clr_nxt;
    logic             late_hit;

    // Handshake: auto_ref is a level request held by the counter; clr_ref is the
    // one-cycle acknowledge in DONE, after which the counter drops auto_ref.
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        case (state)
            S_IDLE: begin
                if (auto_ref && !xfer_busy) begin
                    state_nxt = S_PRE;
                end
            end
            S_PRE: begin
                if (RP_LOAD == '0) begin
                    state_nxt = S_AREF;
                end else begin
                    state_nxt = S_WAIT_RP;
                    wait_nxt  = RP_LOAD;
                end
            end
            S_WAIT_RP: begin
                if (wait_cnt <= ONE) begin
                    state_nxt = S_AREF;
                    wait_nxt  = '0;
                end else begin
                    wait_nxt = wait_cnt - ONE;
                end
            end
            S_AREF: begin
                if (RFC_LOAD == '0) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_WAIT_RFC;
                    wait_nxt  = RFC_LOAD;
                end
            end
            S_WAIT_RFC: begin
                if (wait_cnt <= ONE) begin
                    state_nxt = S_DONE;
                    wait_nxt  = '0;
                end else begin
                    wait_nxt = wait_cnt - ONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                wait_nxt  = '0;
            end
        endcase
    end

    // Lateness only accrues while a due refresh is blocked by a transfer.
    always_comb begin
        late_nxt = late_cnt;
        if (state == S_IDLE) begin
            if (state_nxt == S_PRE) begin
                late_nxt = '0;
            end else if (auto_ref && xfer_busy && (late_cnt != LATE_LIM)) begin
                late_nxt = late_cnt + ONE;
            end
        end
        late_hit = (late_nxt == LATE_LIM);
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_comb begin
        cmd_nxt = CMD_NOP;
        case (state_nxt)
            S_PRE:   cmd_nxt = CMD_PRE;
            S_AREF:  cmd_nxt = CMD_AREF;
            default: cmd_nxt = CMD_NOP;
        endcase
        clr_nxt = (state_nxt == S_DONE);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            late_cnt <= '0;
            ref_late <= 1'b0;
            cmd_q    <= CMD_NOP;
            clr_ref  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            late_cnt <= late_nxt;
            ref_late <= ref_late | late_hit;
            cmd_q    <= cmd_nxt;
            clr_ref  <= clr_nxt;
        end
    end

    assign ref_busy  = (state != S_IDLE);
    assign hold_off  = p_auto_ref | auto_ref | ref_busy;
    assign dbg_state = state;
    assign {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, sd_a10} = cmd_q;

endmodule
